// File: rtl/drac_adc_sequencer_if.sv
// Control/status bundle between the PWM timing block (master) and the ADC sequencer (slave).
// DRAC_ADC_SEQ_STATS_EN adds the overrun_count / seq_count statistics outputs.
interface drac_adc_sequencer_if;
   logic       enable;
   logic       pwm_cycle_start;
   logic       clear_overrun;
   logic       adc_cnv;
   logic       adc_sck;
   logic       adc_data_ready;
   logic       feedback_calculation_start;
   logic [3:0] conv_index;
   logic       busy;
   logic       overrun;
`ifdef DRAC_ADC_SEQ_STATS_EN
   logic [15:0] overrun_count;
   logic [15:0] seq_count;

   modport master (
      output enable, pwm_cycle_start, clear_overrun,
      input  adc_cnv, adc_sck, adc_data_ready, feedback_calculation_start,
      input  conv_index, busy, overrun, overrun_count, seq_count
   );
   modport slave (
      input  enable, pwm_cycle_start, clear_overrun,
      output adc_cnv, adc_sck, adc_data_ready, feedback_calculation_start,
      output conv_index, busy, overrun, overrun_count, seq_count
   );
`else
   modport master (
      output enable, pwm_cycle_start, clear_overrun,
      input  adc_cnv, adc_sck, adc_data_ready, feedback_calculation_start,
      input  conv_index, busy, overrun
   );
   modport slave (
      input  enable, pwm_cycle_start, clear_overrun,
      output adc_cnv, adc_sck, adc_data_ready, feedback_calculation_start,
      output conv_index, busy, overrun
   );
`endif
endinterface

// File: rtl/drac_adc_sequencer.sv
// Per-PWM-period ADC CNV/SCK sequencer; outputs are registered one cycle behind the state, a start seen
// while busy is ignored and flags overrun. DRAC_ADC_SEQ_STATS_EN adds overrun_count / seq_count.
module drac_adc_sequencer #(
   parameter int CNV_DELAY      = 8,
   parameter int CONV_CYCLES    = 40,
   parameter int SCK_HALF       = 2,
   parameter int NUM_BITS       = 16,
   parameter int CONV_PER_CYCLE = 1,
   parameter int ACQ_GAP        = 8
) (
   input logic                 pwmclk,
   input logic                 reset,
   drac_adc_sequencer_if.slave bus
);
   localparam int MAX_A   = (CNV_DELAY > CONV_CYCLES) ? CNV_DELAY : CONV_CYCLES;
   localparam int CNT_MAX = (MAX_A > ACQ_GAP) ? MAX_A : ACQ_GAP;
   localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
   localparam int HALF_W  = (SCK_HALF < 2) ? 1 : $clog2(SCK_HALF);
   localparam int BIT_W   = (NUM_BITS < 2) ? 1 : $clog2(NUM_BITS);

   typedef enum logic [2:0] {IDLE, DELAY, CONVERT, SHIFT, DONE, GAP, FBSTART} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [HALF_W-1:0]  half_q, half_d;
   logic               phase_q, phase_d;
   logic [BIT_W-1:0]   bits_q, bits_d;
   logic [3:0]         idx_q, idx_d;
   logic               adc_cnv_q, adc_cnv_d;
   logic               adc_sck_q, adc_sck_d;
   logic               rdy_q, rdy_d;
   logic               fb_q, fb_d;
   logic               busy_q, busy_d;
   logic [3:0]         conv_index_q, conv_index_d;
   logic               overrun_q, overrun_d;
   logic               ovr_set;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      half_d  = half_q;
      phase_d = phase_q;
      bits_d  = bits_q;
      idx_d   = idx_q;
      ovr_set = bus.enable && bus.pwm_cycle_start && (state_q != IDLE);

      if (!bus.enable) begin
         state_d = IDLE;
         cnt_d   = '0;
         half_d  = '0;
         phase_d = 1'b0;
         bits_d  = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (bus.pwm_cycle_start) begin
                  idx_d   = '0;
                  cnt_d   = '0;
                  state_d = (CNV_DELAY == 0) ? CONVERT : DELAY;
               end
            end
            DELAY: begin
               if (cnt_q == CNT_W'(CNV_DELAY - 1)) begin
                  cnt_d   = '0;
                  state_d = CONVERT;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            CONVERT: begin
               if (cnt_q == CNT_W'(CONV_CYCLES - 1)) begin
                  cnt_d   = '0;
                  half_d  = '0;
                  phase_d = 1'b0;
                  bits_d  = '0;
                  state_d = SHIFT;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            SHIFT: begin
               // phase_q is the SCK level; a bit completes on each high-to-low half boundary
               if (half_q == HALF_W'(SCK_HALF - 1)) begin
                  half_d  = '0;
                  phase_d = !phase_q;
                  if (phase_q) begin
                     if (bits_q == BIT_W'(NUM_BITS - 1)) state_d = DONE;
                     else                                bits_d  = bits_q + BIT_W'(1);
                  end
               end else begin
                  half_d = half_q + HALF_W'(1);
               end
            end
            DONE: begin
               if (idx_q != 4'(CONV_PER_CYCLE - 1)) begin
                  idx_d   = idx_q + 4'd1;
                  cnt_d   = '0;
                  state_d = GAP;
               end else begin
                  state_d = FBSTART;
               end
            end
            GAP: begin
               if (cnt_q == CNT_W'(ACQ_GAP - 1)) begin
                  cnt_d   = '0;
                  state_d = CONVERT;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            FBSTART: state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end

      // Outputs follow the current state one cycle later; enable low silences them at the same edge.
      adc_cnv_d    = bus.enable && (state_q == CONVERT);
      adc_sck_d    = bus.enable && (state_q == SHIFT) && phase_q;
      rdy_d        = bus.enable && (state_q == DONE);
      fb_d         = bus.enable && (state_q == FBSTART);
      busy_d       = bus.enable && (state_q != IDLE);
      conv_index_d = idx_q;
      overrun_d    = ovr_set ? 1'b1 : (bus.clear_overrun ? 1'b0 : overrun_q);
   end

   always_ff @(posedge pwmclk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         half_q       <= '0;
         phase_q      <= 1'b0;
         bits_q       <= '0;
         idx_q        <= '0;
         adc_cnv_q    <= 1'b0;
         adc_sck_q    <= 1'b0;
         rdy_q        <= 1'b0;
         fb_q         <= 1'b0;
         busy_q       <= 1'b0;
         conv_index_q <= '0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         half_q       <= half_d;
         phase_q      <= phase_d;
         bits_q       <= bits_d;
         idx_q        <= idx_d;
         adc_cnv_q    <= adc_cnv_d;
         adc_sck_q    <= adc_sck_d;
         rdy_q        <= rdy_d;
         fb_q         <= fb_d;
         busy_q       <= busy_d;
         conv_index_q <= conv_index_d;
         overrun_q    <= overrun_d;
      end
   end

   assign bus.adc_cnv                    = adc_cnv_q;
   assign bus.adc_sck                    = adc_sck_q;
   assign bus.adc_data_ready             = rdy_q;
   assign bus.feedback_calculation_start = fb_q;
   assign bus.busy                       = busy_q;
   assign bus.conv_index                 = conv_index_q;
   assign bus.overrun                    = overrun_q;

`ifdef DRAC_ADC_SEQ_STATS_EN
   logic [15:0] overrun_count_q, overrun_count_d;
   logic [15:0] seq_count_q, seq_count_d;

   always_comb begin
      overrun_count_d = overrun_count_q;
      seq_count_d     = seq_count_q;
      if (ovr_set) begin
         if (bus.clear_overrun)                  overrun_count_d = 16'd1;
         else if (overrun_count_q != 16'hffff)   overrun_count_d = overrun_count_q + 16'd1;
      end else if (bus.clear_overrun) begin
         overrun_count_d = 16'd0;
      end
      if (fb_d) seq_count_d = seq_count_q + 16'd1;
   end

   always_ff @(posedge pwmclk or posedge reset) begin
      if (reset) begin
         overrun_count_q <= '0;
         seq_count_q     <= '0;
      end else begin
         overrun_count_q <= overrun_count_d;
         seq_count_q     <= seq_count_d;
      end
   end

   assign bus.overrun_count = overrun_count_q;
   assign bus.seq_count     = seq_count_q;
`endif
endmodule

// File: doc/drac_adc_sequencer.md
Name: drac_adc_sequencer

Overview:
- Sequences the shared current-sense ADC conversions for all dRAC motor channels once per PWM period.
- Generates the converter strobes `adc_cnv`/`adc_sck`, plus the `adc_data_ready` and `feedback_calculation_start` pulses consumed by every motor channel.
- Runs entirely in the pwmclk domain, aligned to `pwm_cycle_start`.
- Flags PWM periods that arrive before the previous sequence has finished.

Parameters:
- CNV_DELAY, 8: pwmclk cycles from `pwm_cycle_start` to first CNV rise (0 = rise on next cycle).
- CONV_CYCLES, 40: CNV high time in pwmclk cycles (≥1); covers ADC conversion time.
- SCK_HALF, 2: pwmclk cycles per SCK half-period (≥1).
- NUM_BITS, 16: SCK rising edges per conversion.
- CONV_PER_CYCLE, 1: conversions per PWM period (1..15).
- ACQ_GAP, 8: idle cycles between consecutive conversions within one period (≥1).

Ports:
- pwmclk, input, 1: sole clock.
- reset, input, 1: asynchronous, active-high reset.
- enable, input, 1: sequencer enable; low forces IDLE.
- pwm_cycle_start, input, 1: one-cycle pulse at PWM period start.
- clear_overrun, input, 1: clears sticky overrun.
- adc_cnv, output, 1: ADC convert strobe.
- adc_sck, output, 1: ADC serial clock.
- adc_data_ready, output, 1: one-cycle pulse, shift word complete.
- feedback_calculation_start, output, 1: one-cycle pulse after last conversion of the period.
- conv_index, output, 4: index of current/last conversion in the period.
- busy, output, 1: high in any state except IDLE.
- overrun, output, 1: sticky; start seen while busy.

Behaviour:
- Reset: every output is 0 and the state is IDLE, asynchronously. All outputs are registered.
- States: IDLE, DELAY, CONVERT, SHIFT, DONE, GAP, FBSTART.
- IDLE: `pwm_cycle_start` && `enable` at edge t:
  - `conv_index` := 0.
  - Go to DELAY, or to CONVERT if CNV_DELAY = 0.
  - With CNV_DELAY = 0, `adc_cnv` is high from t+1.
- DELAY: count CNV_DELAY cycles, then CONVERT. With CNV_DELAY = N, `adc_cnv` rises at t+1+N.
- CONVERT: `adc_cnv` = 1 for exactly CONV_CYCLES cycles, then 0; go to SHIFT.
- SHIFT:
  - `adc_sck` starts low for SCK_HALF cycles, then toggles every SCK_HALF cycles.
  - Exactly NUM_BITS rising edges.
  - Leave SHIFT after the NUM_BITS-th falling edge, with `adc_sck` low.
  - SHIFT length is 2·SCK_HALF·NUM_BITS cycles.
- DONE: `adc_data_ready` = 1 for one cycle.
  - If `conv_index` < CONV_PER_CYCLE−1: `conv_index`+1, go to GAP.
  - Otherwise go to FBSTART.
- GAP: ACQ_GAP cycles with `adc_cnv` = `adc_sck` = 0, then CONVERT.
- FBSTART: `feedback_calculation_start` = 1 for one cycle, exactly one cycle after the final `adc_data_ready`; then IDLE.
- `conv_index` holds its last value in IDLE.
- `busy` = (state ≠ IDLE).
- Overrun:
  - `pwm_cycle_start` while busy is ignored (no restart) and sets `overrun` the next cycle.
  - `clear_overrun` clears it.
  - Simultaneous set and clear: set wins.
- `enable` low at any time:
  - Next edge forces IDLE; `adc_cnv` = `adc_sck` = 0.
  - No `adc_data_ready` or `feedback_calculation_start` is issued for the aborted sequence.
  - Internal counters clear; `overrun` is unchanged.
- `pwm_cycle_start` while `enable` is low: ignored, does not set `overrun`.
- Reset mid-sequence: immediate IDLE, no pulses.
- Counters sized for parameter maxima; no wrap occurs within a legal sequence.
- SCK phase is always restarted low at each SHIFT entry.

Optional Feature:
- Macro: DRAC_ADC_SEQ_STATS_EN.
- With the macro defined:
  - Adds output `overrun_count[15:0]`: increments on each ignored busy-start and saturates at 16'hffff.
  - Adds output `seq_count[15:0]`: increments on each `feedback_calculation_start` and wraps.
  - Both cleared by reset; `overrun_count` is also cleared by `clear_overrun`.
  - Simultaneous clear and increment: count = 1.
- Without the macro: the outputs and logic are absent; all other behaviour is identical.

Test Plan:
- Defaults, `enable`=1, `pwm_cycle_start` at cycle 0:
  - `adc_cnv` high cycles 9–48.
  - 16 SCK pulses of period 4, cycles 49–112.
  - `adc_data_ready` at 113; `feedback_calculation_start` at 114; `busy` low at 115.
- CONV_PER_CYCLE=3: three CNV/SHIFT bursts with 8-cycle gaps; `conv_index` 0,1,2; three `adc_data_ready` pulses; one `feedback_calculation_start` after the third.
- Second `pwm_cycle_start` during SHIFT:
  - Sequence completes unchanged; `overrun`=1.
  - `clear_overrun` pulse → 0.
  - Clear and new overrun in the same cycle → stays 1.
- Drop `enable` mid-SHIFT:
  - `adc_sck`/`adc_cnv` low next cycle; no `adc_data_ready`.
  - Re-enable plus start gives a full clean sequence.
- Assert `reset` mid-CONVERT: all outputs 0 asynchronously; after release, the first start runs a nominal sequence.
- With DRAC_ADC_SEQ_STATS_EN:
  - 70000 overruns → `overrun_count`=16'hffff.
  - 65537 completed sequences → `seq_count`=1.
